// File: rtl/smc_timing_counter.sv
// smc_timing_counter
// Timing counter stage feeding the SMC state machine. Captures the per-access
// timing configuration on each accepted access and runs the chip-select
// leading-edge, wait-state and chip-select trailing-edge countdowns. The
// counters re-arm from the stored configuration at the end of each
// sub-access so that multiple accesses repeat the same timing.
module smc_timing_counter #(
   parameter int WS_W   = 8,
   parameter int EDGE_W = 2
) (
   input  logic              sys_clk1,
   input  logic              n_sys_reset1,
   input  logic              valid_access,
   input  logic              le_enable,
   input  logic              ws_enable,
   input  logic              cste_enable,
   input  logic              smc_done,
   input  logic [EDGE_W-1:0] cfg_csle,
   input  logic [WS_W-1:0]   cfg_ws,
   input  logic [EDGE_W-1:0] cfg_cste,
   input  logic [EDGE_W-1:0] cfg_oete,
   output logic [EDGE_W-1:0] r_csle_count,
   output logic [WS_W-1:0]   r_ws_count,
   output logic [EDGE_W-1:0] r_cste_count,
   output logic [EDGE_W-1:0] r_csle_store,
   output logic [EDGE_W-1:0] r_oete_store,
   output logic              counters_idle
);

   // Next value of an edge-width counter: load beats decrement, decrement
   // beats reload, and the decrement saturates at zero instead of wrapping.
   function automatic logic [EDGE_W-1:0] edge_next(
      input logic [EDGE_W-1:0] cnt,
      input logic [EDGE_W-1:0] cfg,
      input logic [EDGE_W-1:0] store,
      input logic              load,
      input logic              en,
      input logic              done
   );
      logic [EDGE_W-1:0] nxt;
      if (load) begin
         nxt = cfg;
      end else if (en) begin
         if (cnt != {EDGE_W{1'b0}}) begin
            nxt = cnt - EDGE_W'(1);
         end else begin
            nxt = {EDGE_W{1'b0}};
         end
      end else if (done) begin
         nxt = store;
      end else begin
         nxt = cnt;
      end
      return nxt;
   endfunction

   // Same priority rules for the wider wait-state counter.
   function automatic logic [WS_W-1:0] ws_next(
      input logic [WS_W-1:0] cnt,
      input logic [WS_W-1:0] cfg,
      input logic [WS_W-1:0] store,
      input logic            load,
      input logic            en,
      input logic            done
   );
      logic [WS_W-1:0] nxt;
      if (load) begin
         nxt = cfg;
      end else if (en) begin
         if (cnt != {WS_W{1'b0}}) begin
            nxt = cnt - WS_W'(1);
         end else begin
            nxt = {WS_W{1'b0}};
         end
      end else if (done) begin
         nxt = store;
      end else begin
         nxt = cnt;
      end
      return nxt;
   endfunction

   logic [EDGE_W-1:0] csle_count_q, csle_count_d;
   logic [WS_W-1:0]   ws_count_q,   ws_count_d;
   logic [EDGE_W-1:0] cste_count_q, cste_count_d;
   logic [EDGE_W-1:0] csle_store_q, csle_store_d;
   logic [WS_W-1:0]   ws_store_q,   ws_store_d;
   logic [EDGE_W-1:0] cste_store_q, cste_store_d;
   logic [EDGE_W-1:0] oete_store_q, oete_store_d;

   // Capture configuration on an accepted access; otherwise hold it.
   always_comb begin
      csle_store_d = csle_store_q;
      ws_store_d   = ws_store_q;
      cste_store_d = cste_store_q;
      oete_store_d = oete_store_q;
      if (valid_access) begin
         csle_store_d = cfg_csle;
         ws_store_d   = cfg_ws;
         cste_store_d = cfg_cste;
         oete_store_d = cfg_oete;
      end else begin
         csle_store_d = csle_store_q;
         ws_store_d   = ws_store_q;
         cste_store_d = cste_store_q;
         oete_store_d = oete_store_q;
      end
   end

   // Countdown next-state; load uses cfg directly so it is visible next cycle.
   always_comb begin
      csle_count_d = edge_next(csle_count_q, cfg_csle, csle_store_q,
                               valid_access, le_enable, smc_done);
      ws_count_d   = ws_next(ws_count_q, cfg_ws, ws_store_q,
                             valid_access, ws_enable, smc_done);
      cste_count_d = edge_next(cste_count_q, cfg_cste, cste_store_q,
                               valid_access, cste_enable, smc_done);
   end

   // State registers, cleared asynchronously by the system reset.
   always_ff @(posedge sys_clk1 or negedge n_sys_reset1) begin
      if (!n_sys_reset1) begin
         csle_count_q <= {EDGE_W{1'b0}};
         ws_count_q   <= {WS_W{1'b0}};
         cste_count_q <= {EDGE_W{1'b0}};
         csle_store_q <= {EDGE_W{1'b0}};
         ws_store_q   <= {WS_W{1'b0}};
         cste_store_q <= {EDGE_W{1'b0}};
         oete_store_q <= {EDGE_W{1'b0}};
      end else begin
         csle_count_q <= csle_count_d;
         ws_count_q   <= ws_count_d;
         cste_count_q <= cste_count_d;
         csle_store_q <= csle_store_d;
         ws_store_q   <= ws_store_d;
         cste_store_q <= cste_store_d;
         oete_store_q <= oete_store_d;
      end
   end

   assign r_csle_count  = csle_count_q;
   assign r_ws_count    = ws_count_q;
   assign r_cste_count  = cste_count_q;
   assign r_csle_store  = csle_store_q;
   assign r_oete_store  = oete_store_q;
   assign counters_idle = (csle_count_q == {EDGE_W{1'b0}}) &&
                          (ws_count_q   == {WS_W{1'b0}})   &&
                          (cste_count_q == {EDGE_W{1'b0}});

endmodule

// File: tb/tb_smc_timing_counter.sv
// Testbench for smc_timing_counter: directed scenarios plus a randomized run
// checked against an integer reference model of the countdown rules.
module tb_smc_timing_counter;
   localparam int WS_W   = 8;
   localparam int EDGE_W = 2;

   logic              sys_clk1;
   logic              n_sys_reset1;
   logic              valid_access, le_enable, ws_enable, cste_enable, smc_done;
   logic [EDGE_W-1:0] cfg_csle, cfg_cste, cfg_oete;
   logic [WS_W-1:0]   cfg_ws;
   logic [EDGE_W-1:0] r_csle_count, r_cste_count, r_csle_store, r_oete_store;
   logic [WS_W-1:0]   r_ws_count;
   logic              counters_idle;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: counts and stores held as plain integers
   int m_csle, m_ws, m_cste, s_csle, s_ws, s_cste, s_oete;

   smc_timing_counter #(.WS_W(WS_W), .EDGE_W(EDGE_W)) dut (
      .sys_clk1      (sys_clk1),
      .n_sys_reset1  (n_sys_reset1),
      .valid_access  (valid_access),
      .le_enable     (le_enable),
      .ws_enable     (ws_enable),
      .cste_enable   (cste_enable),
      .smc_done      (smc_done),
      .cfg_csle      (cfg_csle),
      .cfg_ws        (cfg_ws),
      .cfg_cste      (cfg_cste),
      .cfg_oete      (cfg_oete),
      .r_csle_count  (r_csle_count),
      .r_ws_count    (r_ws_count),
      .r_cste_count  (r_cste_count),
      .r_csle_store  (r_csle_store),
      .r_oete_store  (r_oete_store),
      .counters_idle (counters_idle)
   );

   initial sys_clk1 = 1'b0;
   always #5 sys_clk1 = ~sys_clk1;

   function automatic int model_next(int cnt, int cfg, int store, bit load, bit en, bit done);
      if (load) return cfg;
      if (en)   return (cnt > 0) ? cnt - 1 : 0;
      if (done) return store;
      return cnt;
   endfunction

   task automatic model_clear();
      m_csle = 0; m_ws = 0; m_cste = 0;
      s_csle = 0; s_ws = 0; s_cste = 0; s_oete = 0;
   endtask

   task automatic idle_inputs();
      valid_access = 1'b0; le_enable = 1'b0; ws_enable = 1'b0;
      cste_enable = 1'b0; smc_done = 1'b0;
   endtask

   // Advance one clock with the inputs as currently driven; model follows.
   task automatic step();
      int n_csle, n_ws, n_cste;
      @(posedge sys_clk1);
      n_csle = model_next(m_csle, int'(cfg_csle), s_csle, valid_access, le_enable, smc_done);
      n_ws   = model_next(m_ws,   int'(cfg_ws),   s_ws,   valid_access, ws_enable, smc_done);
      n_cste = model_next(m_cste, int'(cfg_cste), s_cste, valid_access, cste_enable, smc_done);
      if (valid_access) begin
         s_csle = int'(cfg_csle); s_ws = int'(cfg_ws);
         s_cste = int'(cfg_cste); s_oete = int'(cfg_oete);
      end
      m_csle = n_csle; m_ws = n_ws; m_cste = n_cste;
      #1;
   endtask

   task automatic load(int csle, int ws, int cste, int oete);
      idle_inputs();
      valid_access = 1'b1;
      cfg_csle = EDGE_W'(csle); cfg_ws = WS_W'(ws);
      cfg_cste = EDGE_W'(cste); cfg_oete = EDGE_W'(oete);
      step();
      valid_access = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      cfg_csle = '0; cfg_ws = '0; cfg_cste = '0; cfg_oete = '0;
      n_sys_reset1 = 1'b0;
      model_clear();
      repeat (2) @(posedge sys_clk1);
      #2 n_sys_reset1 = 1'b1;
      @(negedge sys_clk1);
      n_checks++;
      if ({r_csle_count, r_ws_count, r_cste_count, r_csle_store, r_oete_store} !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_counts: got %h %h %h %h %h, expected all 0",
                  r_csle_count, r_ws_count, r_cste_count, r_csle_store, r_oete_store);
      end
      n_checks++;
      if (counters_idle !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_idle: got %b, expected 1", counters_idle);
      end
   endtask

   task automatic test_load();
      load(2, 5, 1, 3);
      n_checks++;
      if (r_csle_count !== 2'd2 || r_ws_count !== 8'd5 || r_cste_count !== 2'd1) begin
         n_fail++;
         $display("FAIL load_counts: got %0d/%0d/%0d, expected 2/5/1",
                  r_csle_count, r_ws_count, r_cste_count);
      end
      n_checks++;
      if (r_csle_store !== 2'd2 || r_oete_store !== 2'd3) begin
         n_fail++;
         $display("FAIL load_stores: got csle=%0d oete=%0d, expected 2/3",
                  r_csle_store, r_oete_store);
      end
      n_checks++;
      if (counters_idle !== 1'b0) begin
         n_fail++;
         $display("FAIL load_idle: got %b, expected 0", counters_idle);
      end
   endtask

   task automatic test_ws_countdown();
      ws_enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [WS_W-1:0] exp_ws;
         exp_ws = (i < 5) ? WS_W'(4 - i) : 8'd0;
         step();
         n_checks++;
         if (r_ws_count !== exp_ws) begin
            n_fail++;
            $display("FAIL ws_countdown[%0d]: got %0d, expected %0d", i, r_ws_count, exp_ws);
         end
      end
      ws_enable = 1'b0;
   endtask

   task automatic test_load_priority();
      load(2, 5, 1, 3);
      ws_enable = 1'b1;
      step(); step();
      n_checks++;
      if (r_ws_count !== 8'd3) begin
         n_fail++;
         $display("FAIL prio_mid: got %0d, expected 3", r_ws_count);
      end
      valid_access = 1'b1; smc_done = 1'b1; cfg_ws = 8'd9;
      step();
      idle_inputs();
      n_checks++;
      if (r_ws_count !== 8'd9) begin
         n_fail++;
         $display("FAIL prio_load: got %0d, expected 9", r_ws_count);
      end
   endtask

   task automatic test_reload();
      load(2, 5, 1, 3);
      le_enable = 1'b1; ws_enable = 1'b1; cste_enable = 1'b1;
      repeat (6) step();
      idle_inputs();
      n_checks++;
      if (counters_idle !== 1'b1) begin
         n_fail++;
         $display("FAIL reload_drained: got idle=%b, expected 1", counters_idle);
      end
      smc_done = 1'b1;
      step();
      n_checks++;
      if (r_csle_count !== 2'd2 || r_ws_count !== 8'd5 || r_cste_count !== 2'd1) begin
         n_fail++;
         $display("FAIL reload_counts: got %0d/%0d/%0d, expected 2/5/1",
                  r_csle_count, r_ws_count, r_cste_count);
      end
      cste_enable = 1'b1;
      step();
      idle_inputs();
      n_checks++;
      if (r_cste_count !== 2'd0 || r_csle_count !== 2'd2 || r_ws_count !== 8'd5) begin
         n_fail++;
         $display("FAIL reload_dec_wins: got %0d/%0d/%0d, expected 2/5/0",
                  r_csle_count, r_ws_count, r_cste_count);
      end
   endtask

   task automatic test_cfg_sampling();
      ws_enable = 1'b1;
      step(); step();
      idle_inputs();
      cfg_ws = 8'd7;
      smc_done = 1'b1;
      step();
      smc_done = 1'b0;
      n_checks++;
      if (r_ws_count !== 8'd5) begin
         n_fail++;
         $display("FAIL cfg_sampling: got %0d, expected 5", r_ws_count);
      end
   endtask

   task automatic test_async_reset();
      load(3, 20, 3, 2);
      ws_enable = 1'b1;
      step(); step();
      #3 n_sys_reset1 = 1'b0;
      model_clear();
      #1;
      n_checks++;
      if ({r_csle_count, r_ws_count, r_cste_count, r_csle_store, r_oete_store} !== 16'h0000
          || counters_idle !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset: got %h %h %h %h %h idle=%b, expected all 0 idle=1",
                  r_csle_count, r_ws_count, r_cste_count, r_csle_store, r_oete_store,
                  counters_idle);
      end
      #2 n_sys_reset1 = 1'b1;
      idle_inputs();
      smc_done = 1'b1;
      step();
      smc_done = 1'b0;
      n_checks++;
      if (r_csle_count !== 2'd0 || r_ws_count !== 8'd0 || r_cste_count !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_no_reload: got %0d/%0d/%0d, expected 0/0/0",
                  r_csle_count, r_ws_count, r_cste_count);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         valid_access = ($urandom_range(0, 5) == 0);
         le_enable    = $urandom_range(0, 1) == 1;
         ws_enable    = $urandom_range(0, 2) != 0;
         cste_enable  = $urandom_range(0, 1) == 1;
         smc_done     = ($urandom_range(0, 4) == 0);
         cfg_csle     = EDGE_W'($urandom);
         cfg_ws       = WS_W'($urandom_range(0, 12));
         cfg_cste     = EDGE_W'($urandom);
         cfg_oete     = EDGE_W'($urandom);
         step();
         n_checks++;
         if (int'(r_csle_count) != m_csle || int'(r_ws_count) != m_ws ||
             int'(r_cste_count) != m_cste || int'(r_csle_store) != s_csle ||
             int'(r_oete_store) != s_oete || $isunknown(r_ws_count)) begin
            n_fail++;
            $display("FAIL random[%0d]: got %0d/%0d/%0d st %0d/%0d, expected %0d/%0d/%0d st %0d/%0d",
                     i, r_csle_count, r_ws_count, r_cste_count, r_csle_store, r_oete_store,
                     m_csle, m_ws, m_cste, s_csle, s_oete);
         end
         n_checks++;
         if (counters_idle !== ((m_csle == 0) && (m_ws == 0) && (m_cste == 0))) begin
            n_fail++;
            $display("FAIL random_idle[%0d]: got %b, expected %b", i, counters_idle,
                     (m_csle == 0) && (m_ws == 0) && (m_cste == 0));
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_load();
      test_ws_countdown();
      test_load_priority();
      test_reload();
      test_cfg_sampling();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/smc_timing_counter.md
Name: smc_timing_counter

Overview:
- Timing counter stage directly upstream of the SMC state machine.
- Captures per-access timing configuration on each valid access and runs the three timing countdowns the state machine sequences on:
  - chip-select leading edge (CSLE),
  - wait states (WS),
  - chip-select trailing edge (CSTE).
- Consumes the state machine's `valid_access`, `le_enable`, `ws_enable`, `cste_enable` and `smc_done`.
- Returns registered counts and stored configuration every cycle.

Parameters:
- `WS_W`, 8, width of the wait-state counter and its config field.
- `EDGE_W`, 2, width of the CSLE/CSTE/OETE counters and config fields.

Ports:
- `sys_clk1` in 1: system clock.
- `n_sys_reset1` in 1: system reset.
- `valid_access` in 1: load strobe from the state machine; new access accepted this cycle.
- `le_enable` in 1: CSLE counter decrement enable.
- `ws_enable` in 1: WS counter decrement enable.
- `cste_enable` in 1: CSTE counter decrement enable.
- `smc_done` in 1: last cycle of one sub-access.
- `cfg_csle` in EDGE_W: CS leading-edge delay for the new access.
- `cfg_ws` in WS_W: wait states for the new access.
- `cfg_cste` in EDGE_W: CS trailing-edge delay for the new access.
- `cfg_oete` in EDGE_W: read-strobe trailing edge before CS.
- `r_csle_count` out EDGE_W: CSLE countdown.
- `r_ws_count` out WS_W: wait-state countdown.
- `r_cste_count` out EDGE_W: CSTE countdown.
- `r_csle_store` out EDGE_W: stored CSLE for the current access.
- `r_oete_store` out EDGE_W: stored OETE for the current access.
- `counters_idle` out 1: all three counts are zero.

Behaviour:
- Clock and reset: reset `n_sys_reset1`, asynchronous, active-low; clock `sys_clk1`.
- Reset values: all counts, all stores (including the internal `r_ws_store` and `r_cste_store`) = 0; `counters_idle` = 1.
- All outputs except `counters_idle` are registered; counts update on the `sys_clk1` rising edge. `counters_idle` = AND of all three counts == 0 (combinational from registers).
- Store registers:
  - On `valid_access` = 1, capture `cfg_csle`, `cfg_ws`, `cfg_cste`, `cfg_oete` into `r_csle_store`, `r_ws_store`, `r_cste_store`, `r_oete_store`.
  - Otherwise hold.
- Each counter uses this priority, highest first; all arithmetic is unsigned and saturating at 0, and a counter never wraps from 0 to all-ones:
  1. `valid_access` = 1: load directly from `cfg_*` (not from the store), so the value is visible the cycle after `valid_access`.
  2. Decrement: its own enable = 1 and count != 0 -> count - 1. Enable = 1 with count = 0 -> hold 0.
  3. `smc_done` = 1 (and `valid_access` = 0): reload from its store register. This re-arms the counters for the next sub-access of a multiple access.
  4. Otherwise: hold.
- Counter-to-enable mapping: `r_csle_count` by `le_enable`; `r_ws_count` by `ws_enable`; `r_cste_count` by `cste_enable`.
- Simultaneous events:
  - `valid_access` with any enable or `smc_done`: load wins.
  - Enable with `smc_done`: decrement wins; the reload happens only when no decrement is pending.
- Timing:
  - A WS value of N gives N decrement cycles.
  - With `ws_enable` held high from the cycle after load, `r_ws_count` reads 0 exactly N cycles after load. N = 0 reads 0 immediately.
  - CSLE and CSTE behave identically.
- Config inputs are sampled only on `valid_access`; changes at other times have no effect.
- Reset mid-operation: all registers clear asynchronously. The first edge after reset release behaves as from reset; there is no pending reload.

Test Plan:
- Reset, then `valid_access`=1 with `cfg_csle`=2, `cfg_ws`=5, `cfg_cste`=1, `cfg_oete`=3 -> next cycle counts 2/5/1, `r_csle_store`=2, `r_oete_store`=3, `counters_idle`=0.
- After load (`cfg_ws`=5), hold `ws_enable`=1 -> `r_ws_count` reads 4,3,2,1,0 on successive cycles. Further enable cycles hold 0; the value never reads FF.
- Mid-countdown `r_ws_count`=3, assert `valid_access` and `ws_enable` together with `cfg_ws`=9 -> next cycle `r_ws_count`=9.
- Counts all 0, `smc_done`=1, no enables, stores csle=2/ws=5/cste=1 -> next cycle counts 2/5/1. Then `cste_enable` with `smc_done` both 1 -> CSTE decrements to 0, no reload.
- `cfg_ws` changed to 7 while `valid_access`=0 and `smc_done` pulses -> reload uses the stored 5, not 7.
- Assert `n_sys_reset1`=0 between clock edges during a countdown -> all outputs 0 immediately and `counters_idle`=1. Release, then `smc_done`=1 -> counts stay 0.
